serial_parity_framer: RTL
=========================

SERIAL_PARITY_FRAMER -- requirements
Module: serial_parity_framer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 2..64.
REQ-002 SHALL have parameter ODD_PARITY, default 0; 0 = even parity, 1 = odd parity.
REQ-003 SHALL have parameter CNT_W, default 8, width of the error counter.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  x is accepted at a posedge only when this is 1.
REQ-007 SHALL have port x  input  1  serial data or parity bit.
REQ-008 SHALL have port mode  input  1  0 = generate, 1 = check; sampled only on the first bit of a frame.
REQ-009 SHALL have port z  output  1  registered running parity of accepted data bits, XOR ODD_PARITY.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when a frame completes.
REQ-011 SHALL have port par_bit  output  1  final parity of the frame; valid while frame_done=1.
REQ-012 SHALL have port err  output  1  one-cycle pulse with frame_done, check mode only, when the received parity mismatches.
REQ-013 SHALL have port err_cnt  output  CNT_W  saturating count of errored frames.
REQ-014 SHALL have port busy  output  1  1 when the state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, DATA and CHECK.
REQ-016 IDLE, in_valid=1: SHALL latch mode, set par=x, set bit count=1, and go to DATA.
REQ-017 DATA, in_valid=1: SHALL set par^=x and increment the count.
REQ-018 On accepting data bit DATA_BITS in generate mode: SHALL go to IDLE and, next cycle, assert frame_done=1 and par_bit=par^ODD_PARITY.
REQ-019 On accepting data bit DATA_BITS in check mode: SHALL go to CHECK with no frame_done.
REQ-020 CHECK, in_valid=1: x is the received parity bit; SHALL go to IDLE and, next cycle, assert frame_done=1 and par_bit=expected parity.
REQ-021 CHECK, in_valid=1: SHALL also assert err=(x != expected) and increment err_cnt when err=1.
REQ-022 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 z SHALL update on every accepted data bit, with 1-cycle latency.
REQ-024 z SHALL hold through CHECK.
REQ-025 z SHALL return to ODD_PARITY on the first bit of the next frame, taking the value x^ODD_PARITY.
REQ-026 in_valid=0 SHALL hold state, count, par and z, and force frame_done and err to 0; gaps of any length are legal.
REQ-027 Changes on mode after a frame's first bit SHALL be ignored until the next frame.
REQ-028 A bit accepted in the same cycle as a frame_done pulse SHALL start the next frame; back-to-back frames SHALL incur no dead cycle.
REQ-029 The bit count SHALL be sized $clog2(DATA_BITS+1) and SHALL never exceed DATA_BITS.

Reset
REQ-030 rst=1 at a posedge SHALL force: state=IDLE, count=0, par=0, z=ODD_PARITY, frame_done=0, par_bit=0, err=0, err_cnt=0, busy=0.
REQ-031 Reset mid-frame SHALL discard the partial frame without pulsing frame_done or err.
REQ-032 rst SHALL take priority over in_valid in the same cycle.

Structure
REQ-033 State encoding (IDLE/DATA/CHECK) and the mode constants (MODE_GEN=0, MODE_CHK=1) SHALL live in shared package parity_fsm_pkg.
REQ-034 The saturating error counter SHALL be a sub-module, sat_counter, parameterised by width, with inc and synchronous rst inputs.
REQ-035 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Verification (DATA_BITS=8, CNT_W=8)
REQ-036 Generate, even parity, bits 1,0,1,1,0,0,0,0 with in_valid held 1 -> frame_done=1 and par_bit=1 one cycle after the 8th bit; z sequence 1,1,0,1,1,1,1,1.
REQ-037 Same bits with ODD_PARITY=1 -> par_bit=0; z=1 after reset.
REQ-038 Check mode, same 8 bits then parity 1 -> frame_done=1, err=0, err_cnt=0.
REQ-039 Next frame, same 8 bits then parity 0 -> err=1, err_cnt=1.
REQ-040 Random in_valid gaps (0..5 cycles) between bits of the REQ-036 frame -> identical par_bit; frame_done one cycle after the last accepted bit.
REQ-041 rst asserted after 5 bits, followed by a fresh 8-bit frame of all 1s -> no pulse during reset; par_bit=0 for the new frame; mode toggled mid-frame has no effect.
REQ-042 300 consecutive errored check frames, back-to-back -> err_cnt reaches 255 and holds; no dead cycles between frames.

Source files
------------

// File: rtl/parity_fsm_pkg.sv
// Shared definitions for the serial parity framer: FSM state encoding
// and the generate/check mode constants.
package parity_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, but never wrap past the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/serial_parity_framer.sv
// Serial parity framer: accumulates parity over DATA_BITS serial bits and
// either emits the parity (generate mode) or compares it against a trailing
// received parity bit (check mode), counting mismatched frames.
module serial_parity_framer
    import parity_fsm_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             mode,
    output logic             z,
    output logic             frame_done,
    output logic             par_bit,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    localparam int                  CNT_BITS = $clog2(DATA_BITS + 1);
    localparam logic [CNT_BITS-1:0] LAST     = CNT_BITS'(DATA_BITS);
    localparam logic [CNT_BITS-1:0] LAST_M1  = CNT_BITS'(DATA_BITS - 1);
    localparam logic                ODD      = (ODD_PARITY != 0);

    state_t              state;
    state_t              state_n;
    logic [CNT_BITS-1:0] count;
    logic [CNT_BITS-1:0] count_n;
    logic                par;
    logic                par_n;
    logic                mode_q;
    logic                mode_n;
    logic                z_n;
    logic                done_n;
    logic                par_bit_n;
    logic                err_n;
    logic                busy_n;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: advance only on accepted bits
    always_comb begin
        state_n = state;
        if (in_valid) begin
            case (state)
                IDLE:    state_n = DATA;
                DATA: begin
                    if (count == LAST_M1) begin
                        state_n = (mode_q == MODE_CHK) ? CHECK : IDLE;
                    end
                end
                CHECK:   state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Datapath and output next values; pulses default low every cycle
    always_comb begin
        count_n   = count;
        par_n     = par;
        mode_n    = mode_q;
        z_n       = z;
        done_n    = 1'b0;
        err_n     = 1'b0;
        par_bit_n = par_bit;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    mode_n  = mode;
                    par_n   = x;
                    count_n = CNT_BITS'(1);
                    z_n     = x ^ ODD;
                end
                DATA: begin
                    par_n = par ^ x;
                    z_n   = par ^ x ^ ODD;
                    if (count == LAST_M1) begin
                        if (mode_q == MODE_GEN) begin
                            done_n    = 1'b1;
                            par_bit_n = par ^ x ^ ODD;
                            count_n   = '0;
                        end else begin
                            count_n = LAST;
                        end
                    end else begin
                        count_n = count + CNT_BITS'(1);
                    end
                end
                CHECK: begin
                    done_n    = 1'b1;
                    par_bit_n = par ^ ODD;
                    err_n     = (x != (par ^ ODD));
                    count_n   = '0;
                end
                default: begin
                    count_n = '0;
                end
            endcase
        end
        busy_n = (state_n != IDLE);
    end

    // Register the datapath and every output
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            par        <= 1'b0;
            mode_q     <= MODE_GEN;
            z          <= ODD;
            frame_done <= 1'b0;
            par_bit    <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            count      <= count_n;
            par        <= par_n;
            mode_q     <= mode_n;
            z          <= z_n;
            frame_done <= done_n;
            par_bit    <= par_bit_n;
            err        <= err_n;
            busy       <= busy_n;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_n),
        .count (err_cnt)
    );

endmodule
